// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised up/down counter with a tick prescaler, parallel load,
// wrap/saturate limit handling, a one-cycle terminal-count pulse and a
// built-in seven-segment readout of the count.
//
// Parameters:
//   WIDTH     count register width in bits (>= 1)
//   MODULUS   count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   PRESCALE  enabled clock cycles per count step (>= 1)
//
// Ports:
//   clock       single clock, all state changes on its rising edge
//   clear       synchronous active-high reset
//   enable      advances the prescaler; nothing moves while low
//   up          1 = count up, 0 = count down (sampled on tick cycles)
//   load        synchronous parallel load (clamped to MODULUS-1)
//   load_value  value for load
//   sat_mode    1 = saturate at the limits, 0 = wrap
//   count       current count (registered)
//   tc          registered one-cycle terminal-count pulse
//   hex         active-low segments, digit i at hex[7i+6:7i], bit 6 = g
// -----------------------------------------------------------------------------
module param_updown_counter #(
    parameter int WIDTH    = 16,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic                           clock,
    input  logic                           clear,
    input  logic                           enable,
    input  logic                           up,
    input  logic                           load,
    input  logic [WIDTH-1:0]               load_value,
    input  logic                           sat_mode,
    output logic [WIDTH-1:0]               count,
    output logic                           tc,
    output logic [7*((WIDTH+3)/4)-1:0]     hex
);

    localparam int NUM_DIGITS = (WIDTH + 3) / 4;
    localparam int PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PS_LAST   = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;

    // Next-state logic. Load beats a tick; clear is applied in the register.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        tc_d    = 1'b0;

        if (load) begin
            count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
            presc_d = '0;
        end else if (enable) begin
            if (presc_q == PS_LAST) begin
                // Tick cycle: prescaler restarts and the count takes one step.
                presc_d = '0;
                if (up) begin
                    if (count_q == MAX_COUNT) begin
                        tc_d = 1'b1;
                        if (!sat_mode) begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        tc_d = 1'b1;
                        if (!sat_mode) begin
                            count_d = MAX_COUNT;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

    // Seven-segment glyphs, active low, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The top nibble is zero-extended when WIDTH is not a multiple of 4.
    logic [4*NUM_DIGITS-1:0] count_ext;
    assign count_ext = (4 * NUM_DIGITS)'(count_q);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign hex[7*gi +: 7] = seg7(count_ext[4*gi +: 4]);
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// Bench for param_updown_counter. Three instances with different parameter
// sets share one clock and have independent stimulus:
//   0: WIDTH=4,  MODULUS=10,  PRESCALE=1
//   1: WIDTH=4,  MODULUS=10,  PRESCALE=4
//   2: WIDTH=16, MODULUS=2**16, PRESCALE=1
// A behavioural model (integer count, integer prescale phase) predicts count,
// tc and hex; a compare process checks every instance on each falling edge.
// Directed sequences with literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clr [3];
    logic        en  [3];
    logic        upv [3];
    logic        ld  [3];
    logic        sat [3];
    logic [15:0] lv  [3];

    logic [3:0]  count_a, count_b;
    logic [15:0] count_c;
    logic        tc_a, tc_b, tc_c;
    logic [6:0]  hex_a, hex_b;
    logic [27:0] hex_c;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clock(clock), .clear(clr[0]), .enable(en[0]), .up(upv[0]), .load(ld[0]),
        .load_value(lv[0][3:0]), .sat_mode(sat[0]), .count(count_a), .tc(tc_a), .hex(hex_a)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut_b (
        .clock(clock), .clear(clr[1]), .enable(en[1]), .up(upv[1]), .load(ld[1]),
        .load_value(lv[1][3:0]), .sat_mode(sat[1]), .count(count_b), .tc(tc_b), .hex(hex_b)
    );

    param_updown_counter #(.WIDTH(16)) dut_c (
        .clock(clock), .clear(clr[2]), .enable(en[2]), .up(upv[2]), .load(ld[2]),
        .load_value(lv[2]), .sat_mode(sat[2]), .count(count_c), .tc(tc_c), .hex(hex_c)
    );

    logic [15:0] dc [3];
    logic        dtc[3];
    logic [27:0] dh [3];
    assign dc[0]  = {12'b0, count_a};
    assign dc[1]  = {12'b0, count_b};
    assign dc[2]  = count_c;
    assign dtc[0] = tc_a;
    assign dtc[1] = tc_b;
    assign dtc[2] = tc_c;
    assign dh[0]  = {21'b0, hex_a};
    assign dh[1]  = {21'b0, hex_b};
    assign dh[2]  = hex_c;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int MW[3] = '{4, 4, 16};
    int MM[3] = '{10, 10, 65536};
    int MP[3] = '{1, 4, 1};

    int mc[3];
    int mp[3];
    bit mtc[3];
    bit valid[3] = '{0, 0, 0};

    logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [31:0] exp_hex(input int w, input int c);
        logic [31:0] h;
        h = 32'h0;
        for (int d = 0; d < (w + 3) / 4; d++) begin
            h = h | (32'(GLY[(c >> (4 * d)) & 15]) << (7 * d));
        end
        return h;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (clr[k]) begin
                mc[k] = 0; mp[k] = 0; mtc[k] = 0; valid[k] = 1;
            end else if (ld[k]) begin
                int v;
                v = int'(lv[k]) & ((1 << MW[k]) - 1);
                mc[k] = (v > MM[k] - 1) ? MM[k] - 1 : v;
                mp[k] = 0; mtc[k] = 0;
            end else if (en[k]) begin
                mtc[k] = 0;
                if (mp[k] == MP[k] - 1) begin
                    mp[k] = 0;
                    if (upv[k]) begin
                        if (mc[k] == MM[k] - 1) begin
                            mtc[k] = 1;
                            if (!sat[k]) mc[k] = 0;
                        end else mc[k] = mc[k] + 1;
                    end else begin
                        if (mc[k] == 0) begin
                            mtc[k] = 1;
                            if (!sat[k]) mc[k] = MM[k] - 1;
                        end else mc[k] = mc[k] - 1;
                    end
                end else begin
                    mp[k] = mp[k] + 1;
                end
            end else begin
                mtc[k] = 0;
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (valid[k]) begin
                chk($sformatf("model_count%0d", k), 32'(dc[k]), 32'(mc[k]));
                chk($sformatf("model_tc%0d", k), 32'(dtc[k]), 32'(mtc[k]));
                chk($sformatf("model_hex%0d", k), 32'(dh[k]), exp_hex(MW[k], mc[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b1; en[k] = 1'b0; upv[k] = 1'b1; ld[k] = 1'b0; sat[k] = 1'b0; lv[k] = 16'h0;
        end
        step();
        $display("reset applied to all instances");
        chk("rst_count0", 32'(count_a), 32'h0);
        chk("rst_tc0", 32'(tc_a), 32'h0);
        chk("rst_hex0", 32'(hex_a), 32'h40);
        chk("rst_hex2", 32'(hex_c), 32'({4{7'h40}}));
        chk("rst_count2", 32'(count_c), 32'h0);

        // Up count with wrap on instance 0; prescaled count with an enable gap on 1.
        for (int k = 0; k < 3; k++) clr[k] = 1'b0;
        en[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            en[1] = !(i >= 3 && i <= 5);
            step();
            $display("up step %0d: count_a=%0d tc_a=%0d count_b=%0d", i, count_a, tc_a, count_b);
            if (i == 9) begin
                chk("up9_count", 32'(count_a), 32'd9);
                chk("up9_hex", 32'(hex_a), 32'h10);
                chk("up9_tc", 32'(tc_a), 32'd0);
            end
            if (i == 10) begin
                chk("wrap_count", 32'(count_a), 32'd0);
                chk("wrap_tc", 32'(tc_a), 32'd1);
            end
            if (i == 11) chk("post_wrap_tc", 32'(tc_a), 32'd0);
            if (i == 12) chk("up12_count", 32'(count_a), 32'd2);
            if (i == 6)  chk("presc_before", 32'(count_b), 32'd0);
            if (i == 7)  chk("presc_after", 32'(count_b), 32'd1);
        end

        // Down count from 0: wrap to 9, then saturate at 0.
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        upv[0] = 1'b0;
        step(); $display("down: count_a=%0d tc_a=%0d", count_a, tc_a);
        chk("down_wrap_count", 32'(count_a), 32'd9);
        chk("down_wrap_tc", 32'(tc_a), 32'd1);
        step(); chk("down_8", 32'(count_a), 32'd8);
        step(); chk("down_7", 32'(count_a), 32'd7);
        ld[0] = 1'b1; lv[0] = 16'h0; step(); ld[0] = 1'b0;
        chk("load0_tc", 32'(tc_a), 32'd0);
        sat[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); $display("sat down: count_a=%0d tc_a=%0d", count_a, tc_a);
            chk("sat_count", 32'(count_a), 32'd0);
            chk("sat_tc", 32'(tc_a), 32'd1);
        end
        en[0] = 1'b0; sat[0] = 1'b0;

        // 16-bit natural overflow.
        ld[2] = 1'b1; lv[2] = 16'hFFFE; step(); ld[2] = 1'b0;
        chk("w16_load", 32'(count_c), 32'hFFFE);
        en[2] = 1'b1; upv[2] = 1'b1;
        step(); $display("w16: count_c=%h tc_c=%0d", count_c, tc_c);
        chk("w16_ffff", 32'(count_c), 32'hFFFF);
        chk("w16_ffff_hex", 32'(hex_c), 32'({4{7'h0E}}));
        chk("w16_ffff_tc", 32'(tc_c), 32'd0);
        step(); $display("w16: count_c=%h tc_c=%0d", count_c, tc_c);
        chk("w16_zero", 32'(count_c), 32'h0);
        chk("w16_zero_tc", 32'(tc_c), 32'd1);
        chk("w16_zero_hex", 32'(hex_c), 32'({4{7'h40}}));
        en[2] = 1'b0;

        // Clear beats a simultaneous load and boundary tick.
        ld[0] = 1'b1; lv[0] = 16'h9; step();
        chk("ld9", 32'(count_a), 32'd9);
        clr[0] = 1'b1; lv[0] = 16'h5; en[0] = 1'b1; upv[0] = 1'b1; step();
        $display("clear+load+tick: count_a=%0d tc_a=%0d", count_a, tc_a);
        chk("clr_pri_count", 32'(count_a), 32'd0);
        chk("clr_pri_tc", 32'(tc_a), 32'd0);
        clr[0] = 1'b0; ld[0] = 1'b0; en[0] = 1'b0;

        // Load clamp overriding a tick, then prescale phase restart.
        clr[1] = 1'b1; en[1] = 1'b1; upv[1] = 1'b1; step(); clr[1] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ld[1] = 1'b1; lv[1] = 16'hF; step(); ld[1] = 1'b0;
        $display("load15: count_b=%0d tc_b=%0d", count_b, tc_b);
        chk("clamp_count", 32'(count_b), 32'd9);
        chk("clamp_tc", 32'(tc_b), 32'd0);
        upv[1] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("clamp_hold", 32'(count_b), 32'd9);
        step();
        chk("clamp_step", 32'(count_b), 32'd8);
        upv[1] = 1'b1;
        step(); step();
        clr[1] = 1'b1; step(); clr[1] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("clr_partial_hold", 32'(count_b), 32'd0);
        step();
        chk("clr_partial_step", 32'(count_b), 32'd1);

        // Randomized traffic on all instances.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++) begin
                int sel;
                clr[k] = ($urandom_range(63) == 0);
                ld[k]  = ($urandom_range(15) == 0);
                en[k]  = ($urandom_range(3) != 0);
                upv[k] = 1'($urandom_range(1));
                sat[k] = ($urandom_range(3) == 0);
                sel = int'($urandom_range(2));
                if (sel == 0)      lv[k] = 16'($urandom);
                else if (sel == 1) lv[k] = 16'(65535 - $urandom_range(3));
                else               lv[k] = 16'($urandom_range(3));
            end
            step();
            if (n % 500 == 0) $display("random cycle %0d: count_a=%0d count_b=%0d count_c=%h", n, count_a, count_b, count_c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
